// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI serial-RAM responder: opcodes, FSM states
// and address-phase length.
package spi_ram_pkg;

    localparam logic [7:0] SPI_RAM_READ  = 8'h03;
    localparam logic [7:0] SPI_RAM_WRITE = 8'h02;

    localparam int         ADDR_LEN  = 24;
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_responder_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised level (one clk wide each).
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 target speaking the 23LC1024 READ/WRITE protocol in sequential
// mode, fronting an external byte-wide synchronous memory.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err,
    output state_t            dbg_state
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_meta, mosi;

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        out_sr;
    logic [7:0]        prefetch;
    logic              rd_valid;
    logic              rd_to_pf;

    logic [7:0]        in_byte;
    logic [ADDR_W-1:0] addr_shift;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_clk),
        .level  (sclk_level),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_cs_n),
        .level  (cs_level),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mosi_meta <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi      <= mosi_meta;
        end
    end

    assign in_byte    = {shift_in, mosi};
    assign addr_shift = {addr[ADDR_W-2:0], mosi};
    assign dbg_state  = state;

    // Memory port: mem_we/mem_re are single-cycle strobes with no back-pressure;
    // mem_addr/mem_wdata are valid in the strobe cycle and mem_rdata is taken
    // exactly one cycle after mem_re.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            out_sr    <= '0;
            prefetch  <= '0;
            rd_valid  <= 1'b0;
            rd_to_pf  <= 1'b0;
            spi_miso  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            cmd_err  <= 1'b0;
            busy     <= ~cs_level;
            rd_valid <= mem_re;

            // Late read data after a deselect lands outside RDATA and is dropped.
            if (rd_valid && state == ST_RDATA) begin
                if (rd_to_pf) prefetch <= mem_rdata;
                else          out_sr   <= mem_rdata;
            end

            if (cs_rise) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Mode 0 only: the clock must be idle low at select.
                        if (cs_fall && !sclk_level) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_in <= in_byte[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (in_byte == SPI_RAM_READ || in_byte == SPI_RAM_WRITE) begin
                                    is_read <= (in_byte == SPI_RAM_READ);
                                    state   <= ST_ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr <= addr_shift;
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= '0;
                                if (is_read) begin
                                    state    <= ST_RDATA;
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr_shift;
                                    rd_to_pf <= 1'b0;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            shift_in <= in_byte[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= in_byte;
                                addr      <= addr + ADDR_W'(1);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_fall) begin
                            spi_miso <= out_sr[7];
                            out_sr   <= {out_sr[6:0], 1'b0};
                            if (bit_cnt == 5'd0) begin
                                mem_re   <= 1'b1;
                                mem_addr <= addr + ADDR_W'(1);
                                rd_to_pf <= 1'b1;
                            end
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                out_sr  <= prefetch;
                                addr    <= addr + ADDR_W'(1);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: SPI master driver tasks, a byte memory model on
// the memory port, and write/read scoreboards checked per scenario.
module tb_spi_ram_responder;
  import spi_ram_pkg::*;

  localparam int ADDR_W = 17;
  localparam int HALF   = 6;

  logic              clk = 1'b0;
  logic              resetn;
  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              cmd_err;
  state_t            dbg_state;

  spi_ram_responder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog");
  end

  // external memory model
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // monitor
  logic [24:0] obs_wr_q[$];
  int re_cnt = 0;
  int err_cnt = 0;
  int miso_hi_cnt = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_wr_q.push_back({mem_addr, mem_wdata});
    if (mem_re === 1'b1) re_cnt++;
    if (cmd_err === 1'b1) err_cnt++;
    if (spi_miso === 1'b1) miso_hi_cnt++;
  end

  // scoreboard
  logic [7:0]  exp_q[$];
  logic [24:0] exp_wr_q[$];
  int wr_idx = 0;
  int checks = 0;
  int errors = 0;

  // driver tasks
  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
    r = spi_miso;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(op, rx);
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] v);
    pre_addr = a;
    pre_data = v;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    resetn   = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h exp 00", mem_wdata); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got we=%b re=%b exp 0 0", mem_we, mem_re); end
    checks++; if (busy !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b cmd_err=%b exp 0 0", busy, cmd_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_write();
    logic [7:0]  rx;
    logic [24:0] exp_w;
    cs_low();
    send_hdr(SPI_RAM_WRITE, 24'h000010);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", busy); end
    exp_wr_q.push_back({17'h00010, 8'hA5}); spi_byte(8'hA5, rx);
    exp_wr_q.push_back({17'h00011, 8'h5A}); spi_byte(8'h5A, rx);
    cs_high();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b exp 0", busy); end
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_idx >= obs_wr_q.size()) begin errors++; $display("FAIL write_missing got none exp %h", exp_w); end
      else if (obs_wr_q[wr_idx] !== exp_w) begin errors++; $display("FAIL write_data got %h exp %h", obs_wr_q[wr_idx], exp_w); end
      wr_idx++;
    end
    checks++; if (obs_wr_q.size() != wr_idx) begin errors++; $display("FAIL write_count got %0d exp %0d", obs_wr_q.size(), wr_idx); end
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] e;
    preload(17'h00010, 8'hA5); exp_q.push_back(8'hA5);
    preload(17'h00011, 8'h5A); exp_q.push_back(8'h5A);
    preload(17'h00012, 8'h3C); exp_q.push_back(8'h3C);
    cs_low();
    send_hdr(SPI_RAM_READ, 24'h000010);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, rx);
      e = exp_q.pop_front();
      checks++; if (rx !== e) begin errors++; $display("FAIL read_byte%0d got %h exp %h", i, rx, e); end
    end
    cs_high();
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL read_miso_idle got %b exp 0", spi_miso); end
  endtask

  task automatic test_wrap();
    logic [7:0]  rx;
    logic [24:0] exp_w;
    cs_low();
    send_hdr(SPI_RAM_WRITE, 24'h01FFFF);
    exp_wr_q.push_back({17'h1FFFF, 8'h11}); spi_byte(8'h11, rx);
    exp_wr_q.push_back({17'h00000, 8'h22}); spi_byte(8'h22, rx);
    cs_high();
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_idx >= obs_wr_q.size()) begin errors++; $display("FAIL wrap_missing got none exp %h", exp_w); end
      else if (obs_wr_q[wr_idx] !== exp_w) begin errors++; $display("FAIL wrap_data got %h exp %h", obs_wr_q[wr_idx], exp_w); end
      wr_idx++;
    end
    checks++; if (obs_wr_q.size() != wr_idx) begin errors++; $display("FAIL wrap_count got %0d exp %0d", obs_wr_q.size(), wr_idx); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    int we0, re0, err0, hi0;
    we0  = obs_wr_q.size();
    re0  = re_cnt;
    err0 = err_cnt;
    hi0  = miso_hi_cnt;
    cs_low();
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL ignore_rx1 got %h exp 00", rx); end
    spi_byte(8'hFF, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL ignore_rx2 got %h exp 00", rx); end
    cs_high();
    checks++; if (err_cnt - err0 != 1) begin errors++; $display("FAIL cmd_err_pulses got %0d exp 1", err_cnt - err0); end
    checks++; if (obs_wr_q.size() - we0 != 0) begin errors++; $display("FAIL ignore_we got %0d exp 0", obs_wr_q.size() - we0); end
    checks++; if (re_cnt - re0 != 0) begin errors++; $display("FAIL ignore_re got %0d exp 0", re_cnt - re0); end
    checks++; if (miso_hi_cnt - hi0 != 0) begin errors++; $display("FAIL ignore_miso got %0d high cycles exp 0", miso_hi_cnt - hi0); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL ignore_exit_state got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  rx;
    logic [7:0]  e;
    logic [7:0]  partial;
    logic        b;
    logic [24:0] exp_w;
    // write aborted 5 bits into the second byte
    partial = 8'h88;
    cs_low();
    send_hdr(SPI_RAM_WRITE, 24'h000020);
    exp_wr_q.push_back({17'h00020, 8'h77}); spi_byte(8'h77, rx);
    for (int i = 7; i >= 3; i--) spi_bit(partial[i], b);
    cs_high();
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_idx >= obs_wr_q.size()) begin errors++; $display("FAIL abort_missing got none exp %h", exp_w); end
      else if (obs_wr_q[wr_idx] !== exp_w) begin errors++; $display("FAIL abort_data got %h exp %h", obs_wr_q[wr_idx], exp_w); end
      wr_idx++;
    end
    checks++; if (obs_wr_q.size() != wr_idx) begin errors++; $display("FAIL abort_count got %0d exp %0d", obs_wr_q.size(), wr_idx); end
    // immediately following read decodes normally
    exp_q.push_back(8'h77);
    cs_low();
    send_hdr(SPI_RAM_READ, 24'h000020);
    spi_byte(8'h00, rx);
    e = exp_q.pop_front();
    checks++; if (rx !== e) begin errors++; $display("FAIL b2b_read got %h exp %h", rx, e); end
    cs_high();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    logic [7:0] e;
    logic       b;
    cs_low();
    send_hdr(SPI_RAM_READ, 24'h000010);
    spi_bit(1'b0, b);
    spi_bit(1'b0, b);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (spi_miso !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rst_mid_out got miso=%b we=%b re=%b exp 0 0 0", spi_miso, mem_we, mem_re); end
    checks++; if (mem_addr !== '0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mid_mem got addr=%h wdata=%h exp 0 00", mem_addr, mem_wdata); end
    checks++; if (busy !== 1'b0 || cmd_err !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state got busy=%b err=%b st=%0d exp 0 0 %0d", busy, cmd_err, dbg_state, ST_IDLE); end
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    cs_low();
    send_hdr(SPI_RAM_READ, 24'h000010);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx);
      e = exp_q.pop_front();
      checks++; if (rx !== e) begin errors++; $display("FAIL rst_read_byte%0d got %h exp %h", i, rx, e); end
    end
    cs_high();
  endtask

  task automatic test_random();
    logic [23:0] a24;
    logic [7:0]  d[4];
    logic [7:0]  rx;
    logic [7:0]  e;
    logic [24:0] exp_w;
    int n;
    for (int r = 0; r < 3; r++) begin
      a24 = 24'($urandom_range(0, 24'hFFFFFF));
      n = $urandom_range(2, 4);
      cs_low();
      send_hdr(SPI_RAM_WRITE, a24);
      for (int i = 0; i < n; i++) begin
        d[i] = 8'($urandom_range(0, 255));
        exp_wr_q.push_back({a24[16:0] + 17'(i), d[i]});
        spi_byte(d[i], rx);
      end
      cs_high();
      while (exp_wr_q.size() > 0) begin
        exp_w = exp_wr_q.pop_front();
        checks++;
        if (wr_idx >= obs_wr_q.size()) begin errors++; $display("FAIL rand_wr_missing got none exp %h", exp_w); end
        else if (obs_wr_q[wr_idx] !== exp_w) begin errors++; $display("FAIL rand_wr_data got %h exp %h", obs_wr_q[wr_idx], exp_w); end
        wr_idx++;
      end
      checks++; if (obs_wr_q.size() != wr_idx) begin errors++; $display("FAIL rand_wr_count got %0d exp %0d", obs_wr_q.size(), wr_idx); end
      for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
      cs_low();
      send_hdr(SPI_RAM_READ, a24);
      for (int i = 0; i < n; i++) begin
        spi_byte(8'h00, rx);
        e = exp_q.pop_front();
        checks++; if (rx !== e) begin errors++; $display("FAIL rand_rd addr=%h idx=%0d got %h exp %h", a24, i, rx, e); end
      end
      cs_high();
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_opcode();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
